// File: rtl/serial_pkg.sv
// serial_tx shared types: FSM states, data width, bit-period helper.
// UART_TX_PARITY_EN adds the PARITY state (even parity bit).
package serial_pkg;

  localparam int DATA_W = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  // clk cycles per bit, rounded to nearest
  function automatic int calc_div(
    input int clkrate,
    input int baudrate
  );
    return (clkrate + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Byte valid/ready link into serial_tx.
// master: tx_data, tx_valid out, tx_ready in; slave: reverse.
interface serial_tx_if;
  import serial_pkg::*;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/tx_fifo.sv
// Synchronous FIFO, registered storage, DEPTH a power of 2.
// Ports: clk, rst, push/din, pop/dout, full, empty.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART transmitter: byte FIFO feeding an 8N1/8N2 framer on sdo.
// Ports: clk, rst, tx (serial_tx_if.slave), sdo, busy. UART_TX_PARITY_EN: 8E1/8E2.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKRATE    = 3_579_545,
  parameter int BAUDRATE   = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  tx,
  output logic        sdo,
  output logic        busy
);

  localparam int DIV      = calc_div(CLKRATE, BAUDRATE);
  localparam int STOP_LEN = STOP_BITS * DIV;
  localparam int CW       = $clog2(STOP_LEN);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_LEN - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sdo_q, sdo_d;
  logic              rdy_q;
  logic              push, pop, start_frame;
  logic              full, empty, tick;
  logic [DATA_W-1:0] fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign tx.tx_ready = rdy_q && !full;
  assign push = tx.tx_valid && tx.tx_ready;
  assign sdo  = sdo_q;
  assign busy = (state_q != IDLE) || !empty;
  assign tick = (cnt_q == '0);

  tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (tx.tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? cnt_q : cnt_q - 1'b1;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    sdo_d       = sdo_q;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        sdo_d = 1'b1;
        start_frame = !empty;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          sdo_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = BIT_LOAD;
        end
      end
      DATA: begin
        if (tick && idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          sdo_d   = par_q;
          cnt_d   = BIT_LOAD;
`else
          state_d = STOP;
          sdo_d   = 1'b1;
          cnt_d   = STOP_LOAD;
`endif
        end else if (tick) begin
          idx_d   = idx_q + 1'b1;
          sdo_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = BIT_LOAD;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          sdo_d   = 1'b1;
          cnt_d   = STOP_LOAD;
        end
      end
`endif
      STOP: begin
        // back-to-back frames: no idle gap
        if (tick) begin
          start_frame = !empty;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sdo_d   = 1'b1;
      end
    endcase
    if (start_frame) begin
      pop     = 1'b1;
      state_d = START;
      shreg_d = fifo_dout;
      sdo_d   = 1'b0;
      cnt_d   = BIT_LOAD;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_dout;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      sdo_q   <= 1'b1;
      rdy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      rdy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: timeline reference model of the sdo waveform,
// directed scenarios, random traffic, and a default-rate bit-length probe.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int DEPTH  = 4;
  localparam int SB     = 1;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (10 + PAR + SB - 1) * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdo, busy, sdo2, busy2;

  serial_tx_if u_if ();
  serial_tx_if u_if2 ();

  serial_tx #(
    .CLKRATE    (CLK_HZ),
    .BAUDRATE   (BAUD),
    .FIFO_DEPTH (DEPTH),
    .STOP_BITS  (SB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .tx   (u_if),
    .sdo  (sdo),
    .busy (busy)
  );

  serial_tx dut_def (
    .clk  (clk),
    .rst  (rst),
    .tx   (u_if2),
    .sdo  (sdo2),
    .busy (busy2)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // reference model: bytes waiting, current frame byte and start edge
  logic [7:0] q[$];
  logic [7:0] cur;
  int         cur_start;
  bit         active = 0;
  bit         rdy_en = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_sdo();
    int b;
    if (!active) return 1'b1;
    b = (cyc - cur_start) / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    if (PAR == 1 && b == 9) return ^cur;
    return 1'b1;
  endfunction

  task automatic tick();
    bit acc;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      active = 0;
      rdy_en = 0;
    end else begin
      acc = u_if.tx_valid && rdy_en && (q.size() < DEPTH);
      if (active && cyc == cur_start + FRAME) active = 0;
      if (!active && q.size() > 0) begin
        cur = q.pop_front();
        cur_start = cyc;
        active = 1;
      end
      if (acc) q.push_back(u_if.tx_data);
      rdy_en = 1;
    end
    @(negedge clk);
    check("sdo", sdo, exp_sdo());
    check("busy", busy, active || q.size() > 0);
    check("ready", u_if.tx_ready, rdy_en && q.size() < DEPTH);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] d);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = d;
    tick();
    u_if.tx_valid = 1'b0;
  endtask

  initial begin
    int lows;
    int fall_t;
    u_if.tx_valid  = 1'b0;
    u_if.tx_data   = '0;
    u_if2.tx_valid = 1'b0;
    u_if2.tx_data  = '0;

    ticks(3);
    check("rst_sdo", sdo, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", u_if.tx_ready, 0);
    rst = 1'b0;
    ticks(2);
    check("ready_up", u_if.tx_ready, 1);

    // single 0x55 frame; busy must drop exactly at FRAME after pop
    send(8'h55);
    tick();
    fall_t = -1;
    for (int i = 0; i < FRAME + 20; i++) begin
      tick();
      if (fall_t < 0 && !busy) fall_t = cyc - (cur_start);
    end
    check("busy_fall", fall_t, FRAME);

    // back-to-back frames
    send(8'h00);
    send(8'hFF);
    ticks(2 * FRAME + 20);

    // hold valid while idle: FIFO fills
    u_if.tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      u_if.tx_data = 8'($urandom);
      tick();
    end
    u_if.tx_valid = 1'b0;
    ticks(5 * FRAME + 20);

    // mid-frame reset with two bytes queued
    send(8'hA3);
    send(8'h5C);
    send(8'h96);
    while (cyc < cur_start + 50) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_sdo", sdo, 1);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    ticks(2 * FRAME);
    check("post_rst_idle", busy, 0);

    // parity patterns
    send(8'h07);
    ticks(FRAME + 5);
    send(8'h03);
    ticks(FRAME + 5);

    // random traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      u_if.tx_valid = ($urandom_range(0, 39) == 0);
      u_if.tx_data  = 8'($urandom);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0;
    u_if.tx_valid = 1'b0;
    ticks(DEPTH * FRAME + FRAME + 10);
    check("drained", busy, 0);

    // default-rate instance: start bit length
    @(negedge clk);
    check("def_ready", u_if2.tx_ready, 1);
    u_if2.tx_data  = 8'h01;
    u_if2.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if2.tx_valid = 1'b0;
    lows = 0;
    for (int i = 0; i < 10 && sdo2; i++) @(negedge clk);
    check("def_fall", sdo2, 0);
    for (int i = 0; i < 1000 && !sdo2; i++) begin
      lows++;
      @(negedge clk);
    end
    check("def_bit_len", lows, 373);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
